// File: rtl/mmio_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module      : mmio_arb_pkg
// Description : Shared types and default widths for the FPro MMIO arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
package mmio_arb_pkg;

    localparam int unsigned c_addr_w = 21;
    localparam int unsigned c_data_w = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                wr;
        logic [c_addr_w-1:0] addr;
        logic [c_data_w-1:0] wr_data;
        logic                owner;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/mmio_arb_grant.sv
`default_nettype none
// =============================================================================
// Module      : mmio_arb_grant
// Description : Combinational two-master winner select. MMIO_ARB_RR_EN selects
//               round-robin; otherwise fixed priority with master 0 winning.
// Revision    : 1.0 - initial release
// =============================================================================
module mmio_arb_grant (
    input  logic [1:0] i_req,
`ifdef MMIO_ARB_RR_EN
    input  logic       i_ptr,
`endif
    output logic       o_vld,
    output logic       o_owner
);

    always_comb begin
        o_vld   = |i_req;
`ifdef MMIO_ARB_RR_EN
        // i_ptr holds the last owner, so a tie goes to the other master
        case (i_req)
            2'b01:   o_owner = 1'b0;
            2'b10:   o_owner = 1'b1;
            2'b11:   o_owner = ~i_ptr;
            default: o_owner = 1'b0;
        endcase
`else
        o_owner = i_req[1] & ~i_req[0];
`endif
    end

endmodule
`default_nettype wire

// File: rtl/fpro_mmio_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : fpro_mmio_arbiter
// Description : Serializes one-word transactions from two masters onto the FPro
//               MMIO bus. Define MMIO_ARB_RR_EN for round-robin arbitration.
// Revision    : 1.0 - initial release
// =============================================================================
module fpro_mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
);

    // The command register layout comes from the package; ADDR_W/DATA_W must match it.
    state_t            r_state;
    state_t            w_state_nxt;
    cmd_t              r_cmd;
    cmd_t              w_sel_cmd;
    logic [DATA_W-1:0] r_rd;
    logic [DATA_W-1:0] r_m0_rd_data;
    logic [DATA_W-1:0] r_m1_rd_data;
    logic              w_gnt_vld;
    logic              w_gnt_owner;
`ifdef MMIO_ARB_RR_EN
    logic              r_ptr;
`endif

    mmio_arb_grant u_grant (
        .i_req   ({m1_req, m0_req}),
`ifdef MMIO_ARB_RR_EN
        .i_ptr   (r_ptr),
`endif
        .o_vld   (w_gnt_vld),
        .o_owner (w_gnt_owner)
    );

    always_comb begin
        w_sel_cmd = '0;
        if (w_gnt_owner) begin
            w_sel_cmd.wr      = m1_wr;
            w_sel_cmd.addr    = m1_addr;
            w_sel_cmd.wr_data = m1_wr_data;
            w_sel_cmd.owner   = 1'b1;
        end else begin
            w_sel_cmd.wr      = m0_wr;
            w_sel_cmd.addr    = m0_addr;
            w_sel_cmd.wr_data = m0_wr_data;
            w_sel_cmd.owner   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        mmio_cs      = 1'b0;
        mmio_wr      = 1'b0;
        mmio_rd      = 1'b0;
        mmio_addr    = '0;
        mmio_wr_data = '0;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        m0_rd_data   = r_m0_rd_data;
        m1_rd_data   = r_m1_rd_data;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mmio_cs      = 1'b1;
                mmio_wr      = r_cmd.wr;
                mmio_rd      = ~r_cmd.wr;
                mmio_addr    = r_cmd.addr;
                mmio_wr_data = r_cmd.wr_data;
                w_state_nxt  = RESP;
            end
            RESP: begin
                // Present the fresh read word during the ack; hold regs pick it up next edge
                if (r_cmd.owner) begin
                    m1_ack     = 1'b1;
                    m1_rd_data = r_rd;
                end else begin
                    m0_ack     = 1'b1;
                    m0_rd_data = r_rd;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd        <= '0;
            r_rd         <= '0;
            r_m0_rd_data <= '0;
            r_m1_rd_data <= '0;
`ifdef MMIO_ARB_RR_EN
            r_ptr        <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_cmd <= w_sel_cmd;
                    end
                end
                ISSUE: begin
                    r_rd <= r_cmd.wr ? '0 : mmio_rd_data;
                end
                RESP: begin
                    if (r_cmd.owner) begin
                        r_m1_rd_data <= r_rd;
                    end else begin
                        r_m0_rd_data <= r_rd;
                    end
`ifdef MMIO_ARB_RR_EN
                    r_ptr <= r_cmd.owner;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fpro_mmio_arbiter.md
# fpro_mmio_arbiter

Two-master arbiter that shares the single FPro MMIO bus (feeding the MMIO controller and its 64 slots) between master 0 (CPU-side bus bridge) and master 1 (a secondary requester, e.g. debug/UART loader). Each master issues one-word read/write transactions over a req/ack handshake. The arbiter serializes them onto the bus, one bus cycle per transaction, and returns read data with a one-cycle ack pulse.

## Interface
- ADDR_W, 21, MMIO address width (11 LSBs decoded downstream)
- DATA_W, 32, MMIO data width
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- m0_req / m1_req  input  1  transaction request, level, held until ack
- m0_wr / m1_wr  input  1  1 = write, 0 = read; stable while req high
- m0_addr / m1_addr  input  ADDR_W  word address; stable while req high
- m0_wr_data / m1_wr_data  input  DATA_W  write data; stable while req high
- m0_ack / m1_ack  output  1  one-cycle completion pulse
- m0_rd_data / m1_rd_data  output  DATA_W  read data, valid with ack
- mmio_cs  output  1  bus chip select
- mmio_wr  output  1  bus write strobe
- mmio_rd  output  1  bus read strobe
- mmio_addr  output  ADDR_W  bus address
- mmio_wr_data  output  DATA_W  bus write data
- mmio_rd_data  input  DATA_W  bus read data (combinational from slot, same cycle)

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req high, pick winner, latch {wr, addr, wr_data, owner} into command register, go ISSUE; else stay.
- ISSUE: drive mmio_cs=1, mmio_wr=cmd.wr, mmio_rd=~cmd.wr, addr/wr_data from command register, for exactly one cycle; on a read, capture mmio_rd_data into rd register at end of cycle; go RESP.
- RESP: pulse owner's ack for one cycle, present rd register on owner's rd_data (writes return 0); update priority pointer to owner; go IDLE.
- Outside ISSUE all mmio_* outputs are 0.
- Non-owner ack always 0; rd_data of both masters hold last value between acks, 0 after reset.
- Simultaneous req: winner chosen per arbitration policy (Configuration).
- Master holding req across ack (req still high in the following IDLE cycle) is treated as a new transaction.
- Req raised during ISSUE/RESP is not lost: sampled at next IDLE.
- Requester changing wr/addr/wr_data while req high is not supported; latched value wins.

## Timing
- Reset (async assert): state=IDLE, pointer=1 (master 0 preferred first), all outputs 0, command and rd registers 0. Reset during ISSUE/RESP aborts the transaction with no ack; masters reissue.
- Latency: req seen in IDLE cycle T → bus strobe cycle T+1 → ack cycle T+2.
- Throughput: one transaction per 3 cycles; back-to-back from alternating masters: acks every 3 cycles.
- Exactly one mmio_cs cycle per transaction; mmio_rd and mmio_wr never both 1.

## Configuration
- MMIO_ARB_RR_EN defined: round-robin; on simultaneous req, the master not granted last wins; pointer updated in RESP.
- MMIO_ARB_RR_EN undefined: fixed priority, master 0 always wins ties; pointer register absent; master 1 may starve under continuous master-0 traffic.

## Structure
- Package mmio_arb_pkg: state enum typedef (IDLE, ISSUE, RESP), command struct typedef {wr, addr, wr_data, owner}, ADDR_W/DATA_W default constants.
- Sub-module mmio_arb_grant: combinational winner select from {m1_req, m0_req} and pointer, with the MMIO_ARB_RR_EN policy contained inside it.

## Test plan
- m0 write addr 0x000C0, data 0x000000A5 alone → cycle T+1: mmio_cs=1, mmio_wr=1, addr 0x000C0, data 0xA5; T+2: m0_ack=1, m0_rd_data=0.
- m1 read addr 0x00060, slot returns 0xDEADBEEF in ISSUE → m1_ack at T+2 with m1_rd_data=0xDEADBEEF; m0_ack stays 0.
- Both req high continuously with RR_EN → grants m0, m1, m0, m1; acks 3 cycles apart; without RR_EN → m0 every transaction, m1 never acked.
- m1 req raised during m0 ISSUE → m1 served next, its bus cycle 3 cycles after m0's.
- Reset asserted mid-ISSUE → outputs 0 immediately (asynchronous), no ack; after release, re-held req completes normally with master 0 preferred.
- Idle bus with no req for 10 cycles → mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data all 0 throughout.
